reg_access_ctrl: RTL
====================

// Module: reg_access_ctrl
// PURPOSE
// Sequences all bus-side accesses to the 4-entry I2C register map (addr/wdata/wr_en_wdata/rdata port).
// Round-robin arbitrates NUM_REQ requesters (I2C slave, CDC command handler, ...) onto that port.
// Generates the map's strobe-then-falling-edge write protocol and retries a write lost to a coincident preload.
// Sits between the requesters and the register map; the map's preload port stays owned by internal logic.
// PARAMETERS
// NUM_REQ      2   number of requesters (1..8)
// MAX_ADDRESS  3   highest valid register address; must equal the map's value
// PORTS
// clk          in   1          system clock
// rst_n        in   1          asynchronous reset, active-low
// req_i        in   NUM_REQ    per-requester transaction request, level; sampled only in IDLE
// req_we_i     in   NUM_REQ    1 = write, 0 = read
// req_addr_i   in   NUM_REQ*8  register address, requester k at [8k+7:8k]
// req_wdata_i  in   NUM_REQ*8  write data, same packing
// gnt_o        out  NUM_REQ    one-hot grant, held from accept through RESP
// ack_o        out  NUM_REQ    one-cycle completion pulse to the granted requester
// rsp_rdata_o  out  8          read data, valid with ack_o; 0 for writes and errors
// rsp_err_o    out  1          address > MAX_ADDRESS, valid with ack_o
// busy_o       out  1          state != IDLE
// reg_addr_o   out  8          to map addr
// reg_wdata_o  out  8          to map wdata
// reg_wr_en_o  out  1          to map wr_en_wdata
// reg_rdata_i  in   8          from map rdata (combinational in addr)
// preload_en_i in   1          copy of the map's preload_en (preload wins in the map)
// BEHAVIOUR
// - Reset: state IDLE. RR pointer 0. All outputs 0.
// - All outputs registered. reg_addr_o/reg_wdata_o hold their last value outside a transaction.
// - IDLE: if any req_i is high, pick the first high bit at or after the pointer (cyclic).
//   Latch we/addr/wdata and set gnt_o. Pointer <= granted index + 1 (mod NUM_REQ).
//   Next state: addr > MAX_ADDRESS -> RESP with err=1; write -> WR_STROBE; read -> RD.
// - WR_STROBE: reg_wr_en_o=1, reg_addr_o/reg_wdata_o = latched values.
//   Stay here while preload_en_i=1, so no falling edge occurs. Otherwise -> WR_COMMIT.
// - WR_COMMIT: reg_wr_en_o=0; the map commits at the end of this cycle.
//   If preload_en_i=1 in this cycle, the write is lost -> WR_STROBE (retry, unbounded). Else -> RESP.
// - RD: reg_addr_o = latched addr; capture reg_rdata_i into rsp_rdata_o at the cycle end -> RESP.
// - RESP: ack_o[granted]=1 for exactly one cycle, with rsp_err_o/rsp_rdata_o valid.
//   gnt_o clears on exit -> IDLE.
// - Latency from accepting edge to ack (no preload): write 3 cycles, read 2, error 1.
//   Written data is visible on the map's registers in the ack cycle.
// - req_i is ignored outside IDLE. A requester still high in IDLE starts a new transaction,
//   so it must drop req_i on ack for single accesses. Back-to-back transactions are legal.
// - Payload is latched at accept; requester payload may change after the grant.
// - A requester dropping req_i mid-transaction does not abort it; the ack is still issued.
// - Reset mid-transaction: immediate return to IDLE, outputs 0, no ack.
//   A strobe in flight commits nothing, because the map is reset too.
// - Between transactions reg_wr_en_o is never high: exactly one falling edge per committed write.
// STRUCTURE
// - reg_access_pkg: state_e {IDLE, WR_STROBE, WR_COMMIT, RD, RESP}; REG_ADDR_W=8; REG_DATA_W=8.
// - Sub-module rr_arbiter #(N): req vector, pointer, advance -> one-hot grant + index; combinational pick.
// TESTING
// - Single write, req0 addr=2 data=0xA5 -> wr_en high 1 cycle; map reg2=0xA5 at ack; ack 3 cycles after accept; err=0.
// - Read back, req1 addr=2 -> rsp_rdata=0xA5 with ack_o[1], 2 cycles after accept, wr_en stays 0.
// - req0 and req1 held high continuously, 4 writes each -> grants alternate 0,1,0,1; no starvation.
// - Write addr=7 -> ack in 1 cycle, err=1, rdata=0, reg_wr_en_o never asserted, map unchanged.
// - preload_en_i pulsed in the WR_COMMIT cycle of a write of 0x3C to reg1 (preload 0x11 to reg1)
//   -> retry; final reg1=0x3C; ack delayed by 2 cycles.
// - rst_n asserted during WR_STROBE -> outputs 0 at once, no ack; post-reset, the first request is granted to requester 0.

Source files
------------

// File: rtl/reg_access_pkg.sv
// Shared types and widths for the register-map access sequencer.
package reg_access_pkg;

    localparam int REG_ADDR_W = 8;
    localparam int REG_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_STROBE = 3'd1,
        WR_COMMIT = 3'd2,
        RD        = 3'd3,
        RESP      = 3'd4
    } state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer, cyclic.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic [IDX_W-1:0] next_ptr,
    output logic             valid
);

    always_comb begin
        int               j;
        logic [IDX_W-1:0] j_idx;
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        j_idx = '0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            j_idx = IDX_W'(j);
            if (!valid && req[j_idx]) begin
                valid      = 1'b1;
                idx        = j_idx;
                gnt[j_idx] = 1'b1;
            end
        end
    end

    // Pointer moves one past the winner so the winner becomes lowest priority.
    assign next_ptr = (idx == IDX_W'(N - 1)) ? '0 : idx + IDX_W'(1);

endmodule

// File: rtl/reg_access_ctrl.sv
// Arbitrates requesters onto the register map port and sequences its
// strobe-then-falling-edge write protocol, retrying writes lost to preload.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | no transaction; arbitrate and latch payload of the winner
// WR_STROBE | reg_wr_en_o high; held here while preload is active
// WR_COMMIT | reg_wr_en_o low; map commits at cycle end unless preload hits
// RD        | address on the map; rdata captured at cycle end
// RESP      | one-cycle ack to the granted requester, response valid
module reg_access_ctrl
    import reg_access_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int MAX_ADDRESS = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ-1:0]            req_we_i,
    input  logic [NUM_REQ*REG_ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*REG_DATA_W-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [NUM_REQ-1:0]            ack_o,
    output logic [REG_DATA_W-1:0]         rsp_rdata_o,
    output logic                          rsp_err_o,
    output logic                          busy_o,
    output logic [REG_ADDR_W-1:0]         reg_addr_o,
    output logic [REG_DATA_W-1:0]         reg_wdata_o,
    output logic                          reg_wr_en_o,
    input  logic [REG_DATA_W-1:0]         reg_rdata_i,
    input  logic                          preload_en_i
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam logic [REG_ADDR_W-1:0] MAX_ADDR = REG_ADDR_W'(MAX_ADDRESS);

    state_e                  state;
    logic [IDX_W-1:0]        rr_ptr;
    logic [NUM_REQ-1:0]      arb_gnt;
    logic [IDX_W-1:0]        arb_idx;
    logic [IDX_W-1:0]        arb_next;
    logic                    arb_valid;
    logic                    sel_we;
    logic [REG_ADDR_W-1:0]   sel_addr;
    logic [REG_DATA_W-1:0]   sel_wdata;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req      (req_i),
        .ptr      (rr_ptr),
        .gnt      (arb_gnt),
        .idx      (arb_idx),
        .next_ptr (arb_next),
        .valid    (arb_valid)
    );

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (arb_idx == IDX_W'(k)) begin
                sel_we    = req_we_i[k];
                sel_addr  = req_addr_i[k*REG_ADDR_W +: REG_ADDR_W];
                sel_wdata = req_wdata_i[k*REG_DATA_W +: REG_DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            gnt_o       <= '0;
            ack_o       <= '0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            busy_o      <= 1'b0;
            reg_addr_o  <= '0;
            reg_wdata_o <= '0;
            reg_wr_en_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        gnt_o  <= arb_gnt;
                        rr_ptr <= arb_next;
                        busy_o <= 1'b1;
                        // Out-of-range accesses never touch the map port.
                        if (sel_addr > MAX_ADDR) begin
                            state     <= RESP;
                            ack_o     <= arb_gnt;
                            rsp_err_o <= 1'b1;
                        end else if (sel_we) begin
                            state       <= WR_STROBE;
                            reg_addr_o  <= sel_addr;
                            reg_wdata_o <= sel_wdata;
                            reg_wr_en_o <= 1'b1;
                        end else begin
                            state      <= RD;
                            reg_addr_o <= sel_addr;
                        end
                    end
                end
                WR_STROBE: begin
                    // Dropping the strobe during preload would yield a lost edge.
                    if (!preload_en_i) begin
                        state       <= WR_COMMIT;
                        reg_wr_en_o <= 1'b0;
                    end
                end
                WR_COMMIT: begin
                    if (preload_en_i) begin
                        state       <= WR_STROBE;
                        reg_wr_en_o <= 1'b1;
                    end else begin
                        state <= RESP;
                        ack_o <= gnt_o;
                    end
                end
                RD: begin
                    state       <= RESP;
                    rsp_rdata_o <= reg_rdata_i;
                    ack_o       <= gnt_o;
                end
                RESP: begin
                    state       <= IDLE;
                    gnt_o       <= '0;
                    ack_o       <= '0;
                    rsp_rdata_o <= '0;
                    rsp_err_o   <= 1'b0;
                    busy_o      <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    gnt_o       <= '0;
                    ack_o       <= '0;
                    rsp_rdata_o <= '0;
                    rsp_err_o   <= 1'b0;
                    busy_o      <= 1'b0;
                    reg_wr_en_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
